// File: rtl/fifo_sync_param.sv
// fifo_sync_param: synchronous FIFO with registered read data, wrap-bit
// pointers and occupancy/threshold status flags.
// Ports: clk, rst (sync, active-low), push/pop requests, data_in,
//        data_out (registered), rd_valid, full, empty, almost_full,
//        almost_empty, count (0..DEPTH).
// Optional: define FIFO_SYNC_PARAM_ERR_EN to add sticky ovf/udf flags and
//        their err_clr input.
module fifo_sync_param #(
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
`ifdef FIFO_SYNC_PARAM_ERR_EN
   output logic              ovf,
   output logic              udf,
   input  logic              err_clr,
`endif
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic [DATA_W-1:0] r_data_out;
   logic              r_rd_valid;

   logic [AW:0]       w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_push_ok;
   logic              w_pop_ok;

   // Flags come from the pointer registers only.
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);

   // A push into a full FIFO is still fine when a pop frees the slot.
   assign w_pop_ok  = pop & ~w_empty;
   assign w_push_ok = push & (~w_full | w_pop_ok);

   assign count        = w_count;
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_full  = (w_count >= AF_L);
   assign almost_empty = (w_count <= AE_L);
   assign data_out     = r_data_out;
   assign rd_valid     = r_rd_valid;

   // Storage is not reset; writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (rst && w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_data_out <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_pop_ok;
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         // When full, read and write share an address; the read
         // still returns the old entry.
         if (w_pop_ok) begin
            r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
            r_rd_ptr   <= r_rd_ptr + 1'b1;
         end
      end
   end

`ifdef FIFO_SYNC_PARAM_ERR_EN
   logic r_ovf;
   logic r_udf;

   assign ovf = r_ovf;
   assign udf = r_udf;

   // A new error event beats a coincident clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (push && !w_push_ok) begin
            r_ovf <= 1'b1;
         end else if (err_clr) begin
            r_ovf <= 1'b0;
         end
         if (pop && !w_pop_ok) begin
            r_udf <= 1'b1;
         end else if (err_clr) begin
            r_udf <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: self-checking bench for fifo_sync_param with a
// queue-based reference model and an output scoreboard.
module tb_fifo_sync_param;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          push;
   logic          pop;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [4:0]    count;
`ifdef FIFO_SYNC_PARAM_ERR_EN
   logic          ovf;
   logic          udf;
   logic          err_clr;
`endif

   fifo_sync_param #(
      .DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .data_in(data_in),
      .data_out(data_out),
      .rd_valid(rd_valid),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
`ifdef FIFO_SYNC_PARAM_ERR_EN
      .ovf(ovf),
      .udf(udf),
      .err_clr(err_clr),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] sb[$];
   logic [DW-1:0] last_out;

   typedef struct {
      bit            p;
      bit            q;
      logic [DW-1:0] d;
      int            cnt;
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic check_status();
      int n;
      logic [DW-1:0] v;
      n = mq.size();
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(n >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
      if (sb.size() > 0) begin
         v = sb.pop_front();
         chk("rd_valid", 32'(rd_valid), 32'd1);
         chk("data_out", 32'(data_out), 32'(v));
         last_out = v;
      end else begin
         chk("rd_valid_idle", 32'(rd_valid), 32'd0);
         chk("data_out_hold", 32'(data_out), 32'(last_out));
      end
   endtask

   task automatic step(input bit p, input bit q, input logic [DW-1:0] d);
      int n;
      bit pa;
      bit qa;
      @(negedge clk);
      push = p;
      pop = q;
      data_in = d;
      n = mq.size();
      qa = q && (n > 0);
      pa = p && ((n < DEPTH) || qa);
      if (qa) sb.push_back(mq.pop_front());
      if (pa) mq.push_back(d);
      @(posedge clk);
      #1;
      check_status();
   endtask

   task automatic do_reset(input bit p);
      @(negedge clk);
      rst = 1'b0;
      push = p;
      pop = p;
      data_in = 16'hA5A5;
      @(posedge clk);
      #1;
      rst = 1'b1;
      push = 1'b0;
      pop = 1'b0;
      mq.delete();
      sb.delete();
      last_out = '0;
      chk("rst_data_out", 32'(data_out), 32'd0);
      check_status();
   endtask

   initial begin
      rst = 1'b0;
      push = 1'b0;
      pop = 1'b0;
      data_in = '0;
      last_out = '0;
`ifdef FIFO_SYNC_PARAM_ERR_EN
      err_clr = 1'b0;
`endif

      tv[0]  = '{1'b0, 1'b1, 16'h0000, 0};
      tv[1]  = '{1'b1, 1'b1, 16'h00A1, 1};
      tv[2]  = '{1'b1, 1'b0, 16'h00A2, 2};
      tv[3]  = '{1'b1, 1'b0, 16'h00A3, 3};
      tv[4]  = '{1'b1, 1'b1, 16'h00A4, 3};
      tv[5]  = '{1'b0, 1'b1, 16'h0000, 2};
      tv[6]  = '{1'b0, 1'b0, 16'h0000, 2};
      tv[7]  = '{1'b0, 1'b1, 16'h0000, 1};
      tv[8]  = '{1'b0, 1'b1, 16'h0000, 0};
      tv[9]  = '{1'b0, 1'b1, 16'h0000, 0};
      tv[10] = '{1'b1, 1'b0, 16'h00A5, 1};
      tv[11] = '{1'b1, 1'b1, 16'h00A6, 1};

      do_reset(1'b0);
      for (int i = 0; i < 12; i++) begin
         step(tv[i].p, tv[i].q, tv[i].d);
         chk("vec_count", 32'(count), 32'(tv[i].cnt));
      end

      // fill to full, then drain in order
      do_reset(1'b0);
      for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 16'(i));
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd16);
      for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 16'h0);
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_last", 32'(data_out), 32'h10);

      // streaming across pointer wrap
      do_reset(1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'(16'h0200 + i));
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 16'(16'h0300 + i));
      chk("stream_count", 32'(count), 32'd10);

      // full with simultaneous push/pop
      do_reset(1'b0);
      for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 16'(16'h0400 + i));
      step(1'b1, 1'b1, 16'hBEEF);
      chk("full_pp_data", 32'(data_out), 32'h0401);
      chk("full_pp_count", 32'(count), 32'd16);

      // empty with simultaneous push/pop: no fall-through
      do_reset(1'b0);
      step(1'b1, 1'b1, 16'h0055);
      chk("empty_pp_count", 32'(count), 32'd1);
      chk("empty_pp_valid", 32'(rd_valid), 32'd0);

      // reset mid-operation discards contents
      do_reset(1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'(16'h0700 + i));
      step(1'b0, 1'b1, 16'h0);
      step(1'b1, 1'b0, 16'h0777);
      chk("pre_rst_count", 32'(count), 32'd7);
      do_reset(1'b1);
      chk("post_rst_count", 32'(count), 32'd0);
      chk("post_rst_empty", 32'(empty), 32'd1);
      step(1'b0, 1'b1, 16'h0);

`ifdef FIFO_SYNC_PARAM_ERR_EN
      do_reset(1'b0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_udf", 32'(udf), 32'd0);
      for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 16'(16'h0800 + i));
      chk("no_ovf_yet", 32'(ovf), 32'd0);
      step(1'b1, 1'b0, 16'hDEAD);
      chk("ovf_set", 32'(ovf), 32'd1);
      for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 16'h0);
      chk("ovf_sticky", 32'(ovf), 32'd1);
      chk("no_udf_yet", 32'(udf), 32'd0);
      step(1'b0, 1'b1, 16'h0);
      chk("udf_set", 32'(udf), 32'd1);
      @(negedge clk);
      err_clr = 1'b1;
      pop = 1'b1;
      @(posedge clk);
      #1;
      chk("udf_set_wins", 32'(udf), 32'd1);
      chk("ovf_cleared", 32'(ovf), 32'd0);
      @(negedge clk);
      pop = 1'b0;
      @(posedge clk);
      #1;
      chk("udf_cleared", 32'(udf), 32'd0);
      @(negedge clk);
      err_clr = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 16: data word width in bits, at least 1.
REQ-002 The block SHALL provide parameter DEPTH, default 16: storage entries; a power of two, at least 2.
REQ-003 The block SHALL provide parameter AF_LEVEL, default DEPTH-4: almost_full threshold, in words.
REQ-004 The block SHALL provide parameter AE_LEVEL, default 2: almost_empty threshold, in words.
REQ-005 The block SHALL define AW as log2(DEPTH), derived and not overridable.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset; synchronous, active-low.
REQ-008 push  input  1  write request.
REQ-009 pop  input  1  read request.
REQ-010 data_in  input  DATA_W  write data.
REQ-011 data_out  output  DATA_W  registered read data.
REQ-012 rd_valid  output  1  high for exactly the cycle after an accepted pop.
REQ-013 full, empty  output  1 each  occupancy flags.
REQ-014 almost_full, almost_empty  output  1 each  threshold flags.
REQ-015 count  output  AW+1  current occupancy, range 0..DEPTH.
REQ-016 ovf, udf, err_clr  output, output, input  1 each  sticky error flags and their clear; present only when FIFO_SYNC_PARAM_ERR_EN is defined.

Function
REQ-017 Read and write pointers SHALL each be AW+1 bits: AW address bits plus one wrap bit; they SHALL increment modulo 2^(AW+1).
REQ-018 empty SHALL be asserted exactly when both pointers are equal in all AW+1 bits.
REQ-019 full SHALL be asserted exactly when the address bits are equal and the wrap bits differ.
REQ-020 count SHALL equal wr_ptr minus rd_ptr, computed modulo 2^(AW+1).
REQ-021 All status outputs SHALL be decoded from registered state only, with no combinational path from push or pop.
REQ-022 A push SHALL be accepted when push is high and either full is low, or pop is high and empty is low.
REQ-023 An accepted push SHALL write data_in to mem[wr_ptr address] and increment wr_ptr.
REQ-024 A pop SHALL be accepted when pop is high and empty is low.
REQ-025 An accepted pop SHALL load data_out with mem[rd_ptr address], increment rd_ptr, and set rd_valid on the next cycle.
REQ-026 data_out SHALL hold its value when no pop is accepted.
REQ-027 Push and pop both accepted in one cycle SHALL leave count unchanged.
REQ-028 When full with push and pop both high, both SHALL be accepted; data_out SHALL receive the old entry, not data_in.
REQ-029 When empty with push and pop both high, only the push SHALL be accepted (no fall-through); rd_valid SHALL stay low.
REQ-030 A push while full without pop SHALL be dropped, leaving memory and pointers unchanged.
REQ-031 A pop while empty SHALL be ignored, leaving data_out unchanged.
REQ-032 almost_full SHALL equal (count >= AF_LEVEL).
REQ-033 almost_empty SHALL equal (count <= AE_LEVEL).

Reset
REQ-034 While rst is low at a clock edge, the block SHALL clear both pointers, data_out, rd_valid, ovf and udf to 0.
REQ-035 Memory contents SHALL NOT be reset.
REQ-036 Reset SHALL take priority over push, pop and err_clr.
REQ-037 Reset asserted mid-operation SHALL discard all stored words.
REQ-038 After reset, outputs SHALL read empty=1, almost_empty=1, full=0, almost_full=0 (for AF_LEVEL>0), count=0.

Configuration
REQ-039 With FIFO_SYNC_PARAM_ERR_EN defined, ovf SHALL set on a rejected push and udf SHALL set on a rejected pop.
REQ-040 With FIFO_SYNC_PARAM_ERR_EN defined, ovf and udf SHALL stay set until err_clr=1 or reset; a set event coincident with err_clr SHALL win.
REQ-041 Without FIFO_SYNC_PARAM_ERR_EN, the ovf, udf and err_clr ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification (defaults DATA_W=16, DEPTH=16, AF_LEVEL=12, AE_LEVEL=2)
REQ-042 Reset, then push 0x0001..0x0010 on 16 consecutive cycles -> count=16, full=1, almost_full from count=12, empty=0.
REQ-043 From full, pop 16 times -> data_out 0x0001..0x0010 in order, each one cycle after its pop with rd_valid=1; ends with empty=1 and count=0.
REQ-044 Fill 10 words, run 40 cycles of simultaneous push/pop -> count stays 10, output order preserved across pointer wrap.
REQ-045 Full plus push=pop=1 with data_in=0xBEEF -> data_out = oldest word, count stays 16; empty plus push=pop=1 -> count=1, rd_valid=0.
REQ-046 With ERR_EN: push while full -> ovf=1 and memory unchanged; pop while empty -> udf=1; err_clr pulse -> both 0.
REQ-047 Reset pulsed at count=7 -> next cycle count=0, empty=1, data_out=0x0000.
